// File: rtl/load_store_queue.sv
// load_store_queue
//   In-order load/store queue between the decoder, the ROB and a single
//   data-cache port. Entries capture missing operands from the RS result bus
//   and from this queue's own result bus. The head entry issues one access
//   at a time. Stores issue only once they reach the ROB head. Load data is
//   sign- or zero-extended, and each completion is broadcast as a one-cycle pulse.
//   A flush discards every entry except a store that is already in flight. An
//   in-flight load that is flushed still waits for its mem_done, but produces no result.
// Ports
//   clk, rst (sync, active high), rdy (global enable), flush
//   iss_*        enqueue request and operands from the decoder; full = backpressure
//   rob_empty, rob_head_id   store commit gating
//   rs_valid/rs_rob_id/rs_value   RS result bus (snooped)
//   mem_*        data-cache request/response handshake
//   lsq_valid/lsq_rob_id/lsq_value   result broadcast (also snooped internally)
module load_store_queue #(
    parameter int DEPTH_BITS = 3,
    parameter int ROB_BITS   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                iss_valid,
    input  logic [3:0]          iss_type,
    input  logic [11:0]         iss_imm,
    input  logic [ROB_BITS-1:0] iss_rob_id,
    input  logic [31:0]         iss_rs1_val,
    input  logic                iss_rs1_dep_v,
    input  logic [ROB_BITS-1:0] iss_rs1_dep,
    input  logic [31:0]         iss_rs2_val,
    input  logic                iss_rs2_dep_v,
    input  logic [ROB_BITS-1:0] iss_rs2_dep,
    output logic                full,
    input  logic                rob_empty,
    input  logic [ROB_BITS-1:0] rob_head_id,
    input  logic                rs_valid,
    input  logic [ROB_BITS-1:0] rs_rob_id,
    input  logic [31:0]         rs_value,
    output logic                mem_req,
    output logic                mem_we,
    output logic [1:0]          mem_size,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_done,
    input  logic [31:0]         mem_rdata,
    output logic                lsq_valid,
    output logic [ROB_BITS-1:0] lsq_rob_id,
    output logic [31:0]         lsq_value
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_n;

    logic [DEPTH-1:0]    e_valid, e_store, e_uns, e_rs1_dv, e_rs2_dv;
    logic [1:0]          e_size    [DEPTH];
    logic [11:0]         e_imm     [DEPTH];
    logic [ROB_BITS-1:0] e_rob     [DEPTH];
    logic [ROB_BITS-1:0] e_rs1_dep [DEPTH];
    logic [ROB_BITS-1:0] e_rs2_dep [DEPTH];
    logic [31:0]         e_rs1     [DEPTH];
    logic [31:0]         e_rs2     [DEPTH];

    logic [DEPTH_BITS-1:0] head, tail, head_n, tail_n;
    logic [DEPTH_BITS:0]   count, count_n;
    logic                  dropped;   // in-flight load was flushed; swallow its completion
    logic                  cur_uns;
    logic [ROB_BITS-1:0]   cur_rob;
    logic                  head_ready, issue, complete, enq, deq, keep, kill;
    logic [31:0]           ext_val;

    // Returns {dep_pending, value} after checking both result buses. The RS bus has priority.
    function automatic logic [32:0] snoop(input logic dv, input logic [ROB_BITS-1:0] dep,
                                          input logic [31:0] val);
        if (dv && rs_valid && rs_rob_id == dep)
            return {1'b0, rs_value};
        else if (dv && lsq_valid && lsq_rob_id == dep)
            return {1'b0, lsq_value};
        else
            return {dv, val};
    endfunction

    assign head_ready = e_valid[head] && !e_rs1_dv[head] && !e_rs2_dv[head] &&
                        (!e_store[head] || (!rob_empty && e_rob[head] == rob_head_id));

    always_comb begin
        state_n  = state;
        issue    = 1'b0;
        complete = 1'b0;
        case (state)
            S_IDLE: if (head_ready && !flush) begin
                issue   = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: if (mem_done) begin
                complete = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)      state <= S_IDLE;
        else if (rdy) state <= state_n;
    end

    // A flushed store that is still in flight stays at the head as the only entry.
    assign enq  = iss_valid && !full && !flush;
    assign deq  = complete && !dropped;
    assign keep = flush && state == S_WAIT && !dropped && e_store[head] && !mem_done;
    assign kill = dropped || (flush && !e_store[head]);

    always_comb begin
        head_n = head + DEPTH_BITS'(deq);
        if (flush) begin
            tail_n  = keep ? head + DEPTH_BITS'(1) : head_n;
            count_n = keep ? (DEPTH_BITS+1)'(1) : '0;
        end else begin
            tail_n  = tail + DEPTH_BITS'(enq);
            count_n = count + (DEPTH_BITS+1)'(enq) - (DEPTH_BITS+1)'(deq);
        end
    end

    always_comb begin
        case (mem_size)
            2'd0:    ext_val = cur_uns ? {24'd0, mem_rdata[7:0]}  : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            2'd1:    ext_val = cur_uns ? {16'd0, mem_rdata[15:0]} : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            default: ext_val = mem_rdata;
        endcase
    end

    // Entry storage: operand snooping, enqueue and dequeue.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i]) begin
                    {e_rs1_dv[i], e_rs1[i]} <= snoop(e_rs1_dv[i], e_rs1_dep[i], e_rs1[i]);
                    {e_rs2_dv[i], e_rs2[i]} <= snoop(e_rs2_dv[i], e_rs2_dep[i], e_rs2[i]);
                end
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++)
                    e_valid[i] <= keep && (DEPTH_BITS'(i) == head);
            end else begin
                if (deq) e_valid[head] <= 1'b0;
                if (enq) begin
                    e_valid[tail]   <= 1'b1;
                    e_store[tail]   <= iss_type[0];
                    e_size[tail]    <= iss_type[2:1];
                    e_uns[tail]     <= iss_type[3];
                    e_imm[tail]     <= iss_imm;
                    e_rob[tail]     <= iss_rob_id;
                    e_rs1_dep[tail] <= iss_rs1_dep;
                    e_rs2_dep[tail] <= iss_rs2_dep;
                    {e_rs1_dv[tail], e_rs1[tail]} <= snoop(iss_rs1_dep_v, iss_rs1_dep, iss_rs1_val);
                    {e_rs2_dv[tail], e_rs2[tail]} <= snoop(iss_rs2_dep_v, iss_rs2_dep, iss_rs2_val);
                end
            end
        end
    end

    // Pointers, memory port and result broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            full       <= 1'b0;
            dropped    <= 1'b0;
            cur_uns    <= 1'b0;
            cur_rob    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_size   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lsq_valid  <= 1'b0;
            lsq_rob_id <= '0;
            lsq_value  <= '0;
        end else if (rdy) begin
            head      <= head_n;
            tail      <= tail_n;
            count     <= count_n;
            full      <= count_n >= (DEPTH_BITS+1)'(DEPTH - 1);
            lsq_valid <= 1'b0;
            if (complete)
                dropped <= 1'b0;
            else if (flush && state == S_WAIT && !e_store[head])
                dropped <= 1'b1;
            if (issue) begin
                mem_req   <= 1'b1;
                mem_we    <= e_store[head];
                mem_size  <= e_size[head];
                mem_addr  <= e_rs1[head] + {{20{e_imm[head][11]}}, e_imm[head]};
                mem_wdata <= e_rs2[head];
                cur_uns   <= e_uns[head];
                cur_rob   <= e_rob[head];
            end
            if (complete) begin
                mem_req <= 1'b0;
                if (!kill) begin
                    lsq_valid  <= 1'b1;
                    lsq_rob_id <= cur_rob;
                    lsq_value  <= mem_we ? 32'd0 : ext_val;
                end
            end
        end
    end
endmodule
